spi_cmd_slave: RTL

SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

---
 rtl/spi_cmd_slave.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_slave.sv
// SPI command slave: receives opcode/data words over SPI, streams an image into
// the core's memory, launches classification and cost requests, and returns the result on MISO.
module spi_cmd_slave #(
  parameter int WORD_W      = 8,
  parameter int IMG_WORDS   = 72,
  parameter int MSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         SCK,
  input  logic                         SS,
  input  logic                         MOSI,
  output logic                         MISO,
  output logic [WORD_W-1:0]            wr_data,
  output logic [$clog2(IMG_WORDS)-1:0] wr_addr,
  output logic                         wr_en,
  output logic                         start,
  output logic                         cost_req,
  output logic [WORD_W-1:0]            cost_label,
  input  logic                         core_done,
  input  logic [WORD_W-1:0]            core_result,
  output logic                         busy
);

  localparam int AW = $clog2(IMG_WORDS);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [WORD_W-1:0] OP_LOAD   = WORD_W'(0);
  localparam logic [WORD_W-1:0] OP_COST   = WORD_W'(1);
  localparam logic [WORD_W-1:0] OP_START  = WORD_W'(2);
  localparam logic [WORD_W-1:0] RESP_ACK  = {WORD_W{1'b1}};
  localparam logic [BW-1:0]     BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [AW-1:0]     ADDR_LAST = AW'(IMG_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_COST_ARG = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] rx_word_q, rx_word_d;
  logic              word_vld_q, word_vld_d;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0] resp_q, resp_d;
  logic              busy_q, busy_d;
  logic              img_valid_q, img_valid_d;
  logic              cls_done_q, cls_done_d;
  logic              pend_cls_q, pend_cls_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              cost_req_q, cost_req_d;
  logic [WORD_W-1:0] cost_label_q, cost_label_d;

  logic [WORD_W-1:0] snap_q, snap_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [BW-1:0]     tx_cnt_q, tx_cnt_d;
  logic              miso_q, miso_d;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic busy_eff;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  // A request finishing this cycle frees the core for a decode in the same cycle.
  assign busy_eff = busy_q & ~core_done;

  // Synchronizers, edge history and word receiver.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_word_d   = rx_word_q;
    word_vld_d  = 1'b0;
    if (ss_rise) begin
      bit_cnt_d = BW'(0);
    end else if (sck_rise && !ss_s) begin
      if (MSB_FIRST != 0) begin
        shift_d = {shift_q[WORD_W-2:0], mosi_s};
      end else begin
        shift_d = {mosi_s, shift_q[WORD_W-1:1]};
      end
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d  = BW'(0);
        rx_word_d  = shift_d;
        word_vld_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Command FSM: decodes one received word per strobe; core_done owns resp.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    resp_d       = resp_q;
    busy_d       = busy_q;
    img_valid_d  = img_valid_q;
    cls_done_d   = cls_done_q;
    pend_cls_d   = pend_cls_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    start_d      = 1'b0;
    cost_req_d   = 1'b0;
    cost_label_d = cost_label_q;

    if (core_done) begin
      busy_d = 1'b0;
      if (busy_q && pend_cls_q) begin
        cls_done_d = 1'b1;
      end else begin
        cls_done_d = cls_done_q;
      end
    end else begin
      busy_d = busy_q;
    end

    if (word_vld_q) begin
      case (state_q)
        S_IDLE: begin
          case (rx_word_q)
            OP_LOAD: begin
              if (busy_eff) begin
                resp_d = RESP_ACK;
              end else begin
                state_d     = S_LOAD;
                addr_d      = AW'(0);
                img_valid_d = 1'b0;
                cls_done_d  = 1'b0;
              end
            end
            OP_START: begin
              resp_d = RESP_ACK;
              if (img_valid_q && !busy_eff) begin
                start_d    = 1'b1;
                busy_d     = 1'b1;
                pend_cls_d = 1'b1;
              end else begin
                start_d = 1'b0;
              end
            end
            OP_COST: begin
              state_d = S_COST_ARG;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
        S_LOAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_word_q;
          if (addr_q == ADDR_LAST) begin
            state_d     = S_IDLE;
            addr_d      = AW'(0);
            img_valid_d = 1'b1;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        S_COST_ARG: begin
          state_d = S_IDLE;
          resp_d  = RESP_ACK;
          if (img_valid_q && cls_done_d) begin
            cost_req_d   = 1'b1;
            cost_label_d = rx_word_q;
            busy_d       = 1'b1;
            pend_cls_d   = 1'b0;
          end else begin
            cost_req_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (core_done) begin
      resp_d = core_result;
    end else begin
      resp_d = resp_d;
    end
  end

  // MISO shifter: snapshot resp at frame start and replay it every word.
  always_comb begin
    snap_d   = snap_q;
    tx_d     = tx_q;
    tx_cnt_d = tx_cnt_q;
    if (ss_fall) begin
      snap_d   = resp_q;
      tx_d     = resp_q;
      tx_cnt_d = BW'(0);
    end else if (sck_fall && !ss_s) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_d     = snap_q;
        tx_cnt_d = BW'(0);
      end else begin
        tx_cnt_d = tx_cnt_q + BW'(1);
        if (MSB_FIRST != 0) begin
          tx_d = {tx_q[WORD_W-2:0], 1'b0};
        end else begin
          tx_d = {1'b0, tx_q[WORD_W-1:1]};
        end
      end
    end else begin
      tx_cnt_d = tx_cnt_q;
    end
    if (ss_s) begin
      miso_d = 1'b0;
    end else if (MSB_FIRST != 0) begin
      miso_d = tx_d[WORD_W-1];
    end else begin
      miso_d = tx_d[0];
    end
  end

  // State registers; the select synchronizer resets to the idle (high) level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync_q   <= {SYNC_STAGES{1'b0}};
      ss_sync_q    <= {SYNC_STAGES{1'b1}};
      mosi_sync_q  <= {SYNC_STAGES{1'b0}};
      sck_prev_q   <= 1'b0;
      ss_prev_q    <= 1'b1;
      bit_cnt_q    <= BW'(0);
      shift_q      <= {WORD_W{1'b0}};
      rx_word_q    <= {WORD_W{1'b0}};
      word_vld_q   <= 1'b0;
      state_q      <= S_IDLE;
      addr_q       <= AW'(0);
      resp_q       <= {WORD_W{1'b0}};
      busy_q       <= 1'b0;
      img_valid_q  <= 1'b0;
      cls_done_q   <= 1'b0;
      pend_cls_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= AW'(0);
      wr_data_q    <= {WORD_W{1'b0}};
      start_q      <= 1'b0;
      cost_req_q   <= 1'b0;
      cost_label_q <= {WORD_W{1'b0}};
      snap_q       <= {WORD_W{1'b0}};
      tx_q         <= {WORD_W{1'b0}};
      tx_cnt_q     <= BW'(0);
      miso_q       <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sck_prev_q   <= sck_prev_d;
      ss_prev_q    <= ss_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_word_q    <= rx_word_d;
      word_vld_q   <= word_vld_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      resp_q       <= resp_d;
      busy_q       <= busy_d;
      img_valid_q  <= img_valid_d;
      cls_done_q   <= cls_done_d;
      pend_cls_q   <= pend_cls_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      start_q      <= start_d;
      cost_req_q   <= cost_req_d;
      cost_label_q <= cost_label_d;
      snap_q       <= snap_d;
      tx_q         <= tx_d;
      tx_cnt_q     <= tx_cnt_d;
      miso_q       <= miso_d;
    end
  end

  assign MISO       = miso_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign start      = start_q;
  assign cost_req   = cost_req_q;
  assign cost_label = cost_label_q;
  assign busy       = busy_q;

endmodule
